// File: rtl/lane_mem_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lane_mem_sequencer                                         |
// | Description : Serialises the three per-lane accesses of the EX/MEM       |
// |               register onto one single-port pixel RAM with a 1-cycle     |
// |               registered read, stalling the pipeline until all lanes     |
// |               are serviced.                                              |
// | Option      : LMS_COALESCE_EN - reads skip lanes whose address repeats   |
// |               a lower lane's address and copy that lane's data.          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module lane_mem_sequencer #(
  parameter int N  = 18,
  parameter int AW = 19
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [AW-1:0]       addr0,
  input  logic [AW-1:0]       addr1,
  input  logic [AW-1:0]       addr2,
  input  logic [2:0][N-1:0]   wdata,
  output logic [AW-1:0]       ram_addr,
  output logic                ram_we,
  output logic [N-1:0]        ram_wdata,
  input  logic [N-1:0]        ram_rdata,
  output logic [2:0][N-1:0]   rdata,
  output logic                rvalid,
  output logic                stall,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE0 = 3'd1,
    S_ISSUE1 = 3'd2,
    S_ISSUE2 = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [2:0][AW-1:0]   cap_addr;
  logic [2:0][N-1:0]    cap_wdata;
  logic                 cap_write;
  logic [AW-1:0]        last_addr;

  // Lane whose read was issued last cycle; its data is on ram_rdata now.
  logic                 pend_valid;
  logic [1:0]           pend_lane;
  logic [2:0][N-1:0]    stage;
  logic [2:0][N-1:0]    merged;
  logic [2:0][N-1:0]    result;

  logic                 req;
  logic                 issuing;
  logic [1:0]           issue_lane;
  logic                 dup1;
  logic                 dup2;

  assign req = mem_read | mem_write;

`ifdef LMS_COALESCE_EN
  // Duplicate lanes only matter for reads; writes must hit the RAM in lane order.
  assign dup1 = !cap_write && (cap_addr[1] == cap_addr[0]);
  assign dup2 = !cap_write && ((cap_addr[2] == cap_addr[0]) || (cap_addr[2] == cap_addr[1]));
`else
  assign dup1 = 1'b0;
  assign dup2 = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode plus stall and issue selection.
  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    issuing    = 1'b0;
    issue_lane = 2'd0;
    case (state)
      S_IDLE: begin
        if (req) begin
          stall     = 1'b1;
          state_nxt = S_ISSUE0;
        end
      end
      S_ISSUE0: begin
        stall      = 1'b1;
        issuing    = 1'b1;
        issue_lane = 2'd0;
        if (!dup1)      state_nxt = S_ISSUE1;
        else if (!dup2) state_nxt = S_ISSUE2;
        else            state_nxt = S_DRAIN;
      end
      S_ISSUE1: begin
        stall      = 1'b1;
        issuing    = 1'b1;
        issue_lane = 2'd1;
        state_nxt  = dup2 ? S_DRAIN : S_ISSUE2;
      end
      S_ISSUE2: begin
        stall      = 1'b1;
        issuing    = 1'b1;
        issue_lane = 2'd2;
        state_nxt  = cap_write ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        stall     = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign rvalid    = (state == S_DONE) && !cap_write;
  assign ram_we    = issuing && cap_write;
  assign ram_addr  = issuing ? cap_addr[issue_lane] : last_addr;
  assign ram_wdata = issuing ? cap_wdata[issue_lane] : '0;

  // Final lane results: fold in the data arriving this cycle, then copy duplicates.
  always_comb begin
    merged = stage;
    if (pend_valid) merged[pend_lane] = ram_rdata;
    result = merged;
    if (dup1) result[1] = merged[0];
    if (dup2) result[2] = (cap_addr[2] == cap_addr[0]) ? merged[0] : merged[1];
  end

  // Request capture, read-data staging and result publication.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_write  <= 1'b0;
      last_addr  <= '0;
      pend_valid <= 1'b0;
      pend_lane  <= 2'd0;
      stage      <= '0;
      rdata      <= '0;
    end else begin
      if (state == S_IDLE && req) begin
        cap_addr  <= {addr2, addr1, addr0};
        cap_wdata <= wdata;
        cap_write <= mem_write;
      end
      if (issuing) last_addr <= ram_addr;
      pend_valid <= issuing && !cap_write;
      pend_lane  <= issue_lane;
      if (pend_valid) stage[pend_lane] <= ram_rdata;
      if (state == S_DRAIN) rdata <= result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lane_mem_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_lane_mem_sequencer                                      |
// | Description : Directed self-checking bench for lane_mem_sequencer with a |
// |               behavioural single-port RAM (registered read).             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_lane_mem_sequencer;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_read;
  logic              mem_write;
  logic [18:0]       addr0, addr1, addr2;
  logic [2:0][17:0]  wdata;
  logic [18:0]       ram_addr;
  logic              ram_we;
  logic [17:0]       ram_wdata;
  logic [17:0]       ram_rdata;
  logic [2:0][17:0]  rdata;
  logic              rvalid;
  logic              stall;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  lane_mem_sequencer #(.N(18), .AW(19)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr0     (addr0),
    .addr1     (addr1),
    .addr2     (addr2),
    .wdata     (wdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .stall     (stall),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural RAM with a preload port and a log of every DUT write.
  logic [17:0] mem [0:(1<<19)-1];
  logic        pre_we = 1'b0;
  logic [18:0] pre_addr = '0;
  logic [17:0] pre_data = '0;
  int          we_count = 0;
  logic [18:0] log_addr [0:31];
  logic [17:0] log_data [0:31];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) begin
      mem[ram_addr]            <= ram_wdata;
      log_addr[we_count[4:0]]  <= ram_addr;
      log_data[we_count[4:0]]  <= ram_wdata;
      we_count                 <= we_count + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic preload(input logic [18:0] a, input logic [17:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
    #1;
  endtask

  // Runs one request from the current IDLE cycle; ends at the IDLE cycle after DONE.
  task automatic run_txn(input logic rd, input logic wr,
                         input logic [18:0] a0, input logic [18:0] a1, input logic [18:0] a2,
                         input logic [17:0] d0, input logic [17:0] d1, input logic [17:0] d2,
                         output int lat, output int st, output int rv,
                         output logic [2:0][17:0] rd_out);
    logic done;
    mem_read = rd; mem_write = wr;
    addr0 = a0; addr1 = a1; addr2 = a2;
    wdata = {d2, d1, d0};
    #1;
    lat = 0; st = 0; rv = 0; rd_out = '0; done = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (!done) begin
        if (stall)  st++;
        if (rvalid) rv++;
        if (busy && !stall) begin
          lat = c; done = 1'b1; rd_out = rdata;
        end
        @(negedge clk);
        if (c == 1) begin mem_read = 1'b0; mem_write = 1'b0; end
        #1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    addr0 = '0; addr1 = '0; addr2 = '0; wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (stall !== 1'b0)   begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    checks++; if (rvalid !== 1'b0)  begin failures++; $display("FAIL reset_rvalid got=%0b exp=0", rvalid); end
    checks++; if (ram_we !== 1'b0)  begin failures++; $display("FAIL reset_ram_we got=%0b exp=0", ram_we); end
    checks++; if (ram_addr !== '0)  begin failures++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
    checks++; if (rdata !== '0)     begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    reset = 1'b0;
  endtask

  task automatic test_mid_reset();
    int base;
    preload(19'h00302, 18'h3FFFF);
    base = we_count;
    mem_write = 1'b1; mem_read = 1'b0;
    addr0 = 19'h00300; addr1 = 19'h00301; addr2 = 19'h00302;
    wdata = {18'h0000C, 18'h0000B, 18'h0000A};
    @(negedge clk); mem_write = 1'b0; #1;          // ISSUE0
    @(negedge clk); #1;                             // ISSUE1
    checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL midreset_issue1_we got=%0b exp=1", ram_we); end
    reset = 1'b1;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL midreset_busy got=%0b exp=0", busy); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL midreset_ram_we got=%0b exp=0", ram_we); end
    checks++; if (stall !== 1'b0)  begin failures++; $display("FAIL midreset_stall got=%0b exp=0", stall); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL midreset_rvalid got=%0b exp=0", rvalid); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (we_count - base !== 2) begin failures++; $display("FAIL midreset_write_count got=%0d exp=2", we_count - base); end
    checks++; if (mem[19'h00302] !== 18'h3FFFF) begin failures++; $display("FAIL midreset_lane2_untouched got=%h exp=3ffff", mem[19'h00302]); end
  endtask

  task automatic test_read();
    int lat, st, rv, base;
    logic [2:0][17:0] r;
    preload(19'h00010, 18'h0003A);
    preload(19'h00011, 18'h2FFFF);
    preload(19'h00012, 18'h00001);
    base = we_count;
    run_txn(1'b1, 1'b0, 19'h00010, 19'h00011, 19'h00012, '0, '0, '0, lat, st, rv, r);
    checks++; if (r !== {18'h00001, 18'h2FFFF, 18'h0003A}) begin failures++; $display("FAIL read_rdata got=%h exp=%h", r, {18'h00001, 18'h2FFFF, 18'h0003A}); end
    checks++; if (rv !== 1)  begin failures++; $display("FAIL read_rvalid_cycles got=%0d exp=1", rv); end
    checks++; if (st !== 5)  begin failures++; $display("FAIL read_stall_cycles got=%0d exp=5", st); end
    checks++; if (lat !== 6) begin failures++; $display("FAIL read_latency got=%0d exp=6", lat); end
    checks++; if (we_count !== base) begin failures++; $display("FAIL read_no_writes got=%0d exp=%0d", we_count, base); end
  endtask

  task automatic test_write();
    int lat, st, rv, base;
    logic [2:0][17:0] r;
    base = we_count;
    run_txn(1'b0, 1'b1, 19'h7FFFF, 19'h00000, 19'h40000, 18'd1, 18'd2, 18'd3, lat, st, rv, r);
    checks++; if (we_count - base !== 3) begin failures++; $display("FAIL write_pulses got=%0d exp=3", we_count - base); end
    checks++; if (log_addr[base[4:0]] !== 19'h7FFFF || log_data[base[4:0]] !== 18'd1)
      begin failures++; $display("FAIL write_order0 got=%h/%h exp=7ffff/1", log_addr[base[4:0]], log_data[base[4:0]]); end
    checks++; if (log_addr[base[4:0]+5'd1] !== 19'h00000 || log_data[base[4:0]+5'd1] !== 18'd2)
      begin failures++; $display("FAIL write_order1 got=%h/%h exp=0/2", log_addr[base[4:0]+5'd1], log_data[base[4:0]+5'd1]); end
    checks++; if (log_addr[base[4:0]+5'd2] !== 19'h40000 || log_data[base[4:0]+5'd2] !== 18'd3)
      begin failures++; $display("FAIL write_order2 got=%h/%h exp=40000/3", log_addr[base[4:0]+5'd2], log_data[base[4:0]+5'd2]); end
    checks++; if (rv !== 0)  begin failures++; $display("FAIL write_rvalid_cycles got=%0d exp=0", rv); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL write_latency got=%0d exp=5", lat); end
    checks++; if (st !== 4)  begin failures++; $display("FAIL write_stall_cycles got=%0d exp=4", st); end
    checks++; if (ram_addr !== 19'h40000 || ram_we !== 1'b0)
      begin failures++; $display("FAIL write_idle_addr_hold got=%h/%0b exp=40000/0", ram_addr, ram_we); end
    checks++; if (rdata !== {18'h00001, 18'h2FFFF, 18'h0003A})
      begin failures++; $display("FAIL write_rdata_hold got=%h exp=%h", rdata, {18'h00001, 18'h2FFFF, 18'h0003A}); end
    run_txn(1'b1, 1'b0, 19'h7FFFF, 19'h00000, 19'h40000, '0, '0, '0, lat, st, rv, r);
    checks++; if (r !== {18'd3, 18'd2, 18'd1}) begin failures++; $display("FAIL write_readback got=%h exp=%h", r, {18'd3, 18'd2, 18'd1}); end
  endtask

  task automatic test_same_addr_write();
    int lat, st, rv;
    logic [2:0][17:0] r;
    run_txn(1'b0, 1'b1, 19'h00100, 19'h00100, 19'h00100, 18'd5, 18'd6, 18'd7, lat, st, rv, r);
    checks++; if (mem[19'h00100] !== 18'd7) begin failures++; $display("FAIL same_addr_last_lane got=%h exp=7", mem[19'h00100]); end
  endtask

  task automatic test_back_to_back();
    int lat, st, rv, base;
    logic [2:0][17:0] r;
    base = we_count;
    run_txn(1'b1, 1'b1, 19'h00200, 19'h00201, 19'h00202, 18'd9, 18'd10, 18'd11, lat, st, rv, r);
    checks++; if (lat !== 5) begin failures++; $display("FAIL both_ops_latency got=%0d exp=5", lat); end
    checks++; if (rv !== 0)  begin failures++; $display("FAIL both_ops_rvalid got=%0d exp=0", rv); end
    checks++; if (we_count - base !== 3) begin failures++; $display("FAIL both_ops_pulses got=%0d exp=3", we_count - base); end
    run_txn(1'b1, 1'b0, 19'h00200, 19'h00201, 19'h00202, '0, '0, '0, lat, st, rv, r);
    checks++; if (lat !== 6) begin failures++; $display("FAIL b2b_read_latency got=%0d exp=6", lat); end
    checks++; if (r !== {18'd11, 18'd10, 18'd9}) begin failures++; $display("FAIL b2b_read_rdata got=%h exp=%h", r, {18'd11, 18'd10, 18'd9}); end
    checks++; if (rv !== 1) begin failures++; $display("FAIL b2b_read_rvalid got=%0d exp=1", rv); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (we_count - base !== 3) begin failures++; $display("FAIL b2b_no_extra_writes got=%0d exp=3", we_count - base); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_no_duplicate got=%0b exp=0", busy); end
  endtask

  task automatic test_coalesce();
    int lat, st, rv;
    int exp_all, exp_part;
    logic [2:0][17:0] r;
`ifdef LMS_COALESCE_EN
    exp_all = 4; exp_part = 5;
`else
    exp_all = 6; exp_part = 6;
`endif
    preload(19'h00055, 18'h01234);
    run_txn(1'b1, 1'b0, 19'h00055, 19'h00055, 19'h00055, '0, '0, '0, lat, st, rv, r);
    checks++; if (r !== {18'h01234, 18'h01234, 18'h01234}) begin failures++; $display("FAIL coal_all_rdata got=%h", r); end
    checks++; if (lat !== exp_all) begin failures++; $display("FAIL coal_all_latency got=%0d exp=%0d", lat, exp_all); end
    checks++; if (rv !== 1) begin failures++; $display("FAIL coal_all_rvalid got=%0d exp=1", rv); end
    run_txn(1'b1, 1'b0, 19'h00010, 19'h00011, 19'h00010, '0, '0, '0, lat, st, rv, r);
    checks++; if (r !== {18'h0003A, 18'h2FFFF, 18'h0003A}) begin failures++; $display("FAIL coal_part_rdata got=%h exp=%h", r, {18'h0003A, 18'h2FFFF, 18'h0003A}); end
    checks++; if (lat !== exp_part) begin failures++; $display("FAIL coal_part_latency got=%0d exp=%0d", lat, exp_part); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_same_addr_write();
    test_back_to_back();
    test_mid_reset();
    test_coalesce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
